// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor datapath.
package sub_pkg;

  parameter int unsigned MaxWidth = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Reset value of every result register, sliced to the instance width.
  localparam logic [MaxWidth-1:0] RESULT_RST = '0;

  // Signed overflow of a - b from the operand MSBs and the result MSB.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - borrow_in.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  always_comb begin
    diff       = a ^ b ^ borrow_in;
    borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full_subtractor cell per clock.
// Start/done/ack handshake; results hold until the next RUN->DONE edge or reset.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ResRst = RESULT_RST[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_reg_q, borrow_reg_d;
  logic             borrow_q, borrow_d;
  logic             overflow_q, overflow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  logic             cell_diff;
  logic             cell_borrow;
  logic [WIDTH-1:0] res_shift;

  full_subtractor u_cell (
    .a          (a_q[0]),
    .b          (b_q[0]),
    .borrow_in  (borrow_reg_q),
    .diff       (cell_diff),
    .borrow_out (cell_borrow)
  );

  // Result fills from the MSB end so bit 0 lands at position 0 after WIDTH shifts.
  assign res_shift = {cell_diff, res_q[WIDTH-1:1]};

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    borrow_reg_d = borrow_reg_q;
    borrow_d     = borrow_q;
    overflow_d   = overflow_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d          = a_in;
          b_d          = b_in;
          a_msb_d      = a_in[WIDTH-1];
          b_msb_d      = b_in[WIDTH-1];
          res_d        = ResRst;
          borrow_reg_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_RUN;
        end
      end

      S_RUN: begin
        res_d        = res_shift;
        borrow_reg_d = cell_borrow;
        a_d          = a_q >> 1;
        b_d          = b_q >> 1;
        if (cnt_q == LastBit) begin
          state_d    = S_DONE;
          diff_d     = res_shift;
          borrow_d   = cell_borrow;
          overflow_d = sub_overflow(a_msb_q, b_msb_q, cell_diff);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      S_DONE: begin
        // ack wins over a simultaneous start; start must be re-raised in IDLE.
        if (ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= ResRst;
      diff_q       <= ResRst;
      cnt_q        <= '0;
      borrow_reg_q <= 1'b0;
      borrow_q     <= 1'b0;
      overflow_q   <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      borrow_reg_q <= borrow_reg_d;
      borrow_q     <= borrow_d;
      overflow_q   <= overflow_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
    end
  end

  always_comb begin
    busy       = (state_q == S_RUN);
    done       = (state_q == S_DONE);
    diff_out   = diff_q;
    borrow_out = borrow_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: drivers push expected results, monitors pop on each rising done.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       bor;
    logic       ovf;
    int         c0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, ack8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bor8, ovf8;
  logic [7:0] diff8;

  logic       start4 = 1'b0, ack4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bor4, ovf4;
  logic [3:0] diff4;

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t q8[$];
  exp_t q4[$];

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start8),
    .a_in       (a8),
    .b_in       (b8),
    .ack        (ack8),
    .busy       (busy8),
    .done       (done8),
    .diff_out   (diff8),
    .borrow_out (bor8),
    .overflow   (ovf8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .a_in       (a4),
    .b_in       (b4),
    .ack        (ack4),
    .busy       (busy4),
    .done       (done4),
    .diff_out   (diff4),
    .borrow_out (bor4),
    .overflow   (ovf4)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the 8-bit instance.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done8 && !prev) begin
        if (q8.size() == 0) begin
          total_cnt++;
          $display("FAIL sb8_underflow: done rose with no expected entry");
        end else begin
          e = q8.pop_front();
          check("diff8", diff8, e.diff);
          check("borrow8", bor8, e.bor);
          check("overflow8", ovf8, e.ovf);
          check("latency8", cyc - e.c0, 8);
        end
      end
      prev = done8;
    end
  end

  // Monitor for the 4-bit instance.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done4 && !prev) begin
        if (q4.size() == 0) begin
          total_cnt++;
          $display("FAIL sb4_underflow: done rose with no expected entry");
        end else begin
          e = q4.pop_front();
          check("result4", {bor4, ovf4, diff4}, {e.bor, e.ovf, e.diff[3:0]});
          check("latency4", cyc - e.c0, 4);
        end
      end
      prev = done4;
    end
  end

  // poke: RUN sample index at which to pulse a stray start (0 = none).
  // hold: cycles to keep ack low in DONE. ack_start: raise start together with ack.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                     input logic eb, input logic eo, input int poke, input int hold,
                     input bit ack_start);
    exp_t e;
    int   nbusy;
    bit   seen;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = 8'h5A;
    e.diff = ed; e.bor = eb; e.ovf = eo; e.c0 = cyc;
    q8.push_back(e);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done8) begin
        seen = 1'b1;
      end else begin
        if (busy8) nbusy++;
        if (poke > 0 && i == poke) start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
      end
    end
    check("done_seen", seen, 1);
    check("busy_cycles", nbusy, 8);
    check("busy_in_done", busy8, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_done", done8, 1);
      check("hold_result", {bor8, ovf8, diff8}, {eb, eo, ed});
    end
    ack8 = 1'b1;
    if (ack_start) begin
      start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    end
    @(negedge clk);
    ack8 = 1'b0; start8 = 1'b0;
    check("ack_to_idle", {busy8, done8}, 0);
    if (ack_start) begin
      @(negedge clk);
      check("no_restart", {busy8, done8}, 0);
      check("result_held_idle", diff8, ed);
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b);
    exp_t       e;
    logic [4:0] full;
    bit         seen;
    full  = {1'b0, a} - {1'b0, b};
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    e.diff = {4'h0, full[3:0]};
    e.bor  = full[4];
    e.ovf  = (a[3] != b[3]) && (full[3] != a[3]);
    e.c0   = cyc;
    q4.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done4) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check("done4_seen", seen, 1);
    ack4 = 1'b1;
    @(negedge clk);
    ack4 = 1'b0;
  endtask

  initial begin
    #3;
    check("reset_outputs", {busy8, done8, bor8, ovf8, diff8}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy8, done8, bor8, ovf8, diff8}, 0);

    op8(8'd25,  8'd10,  8'h0F, 1'b0, 1'b0, 0, 0, 1'b0);
    op8(8'd10,  8'd25,  8'hF1, 1'b1, 1'b0, 0, 0, 1'b0);
    op8(8'h00,  8'h00,  8'h00, 1'b0, 1'b0, 0, 0, 1'b0);
    op8(8'h80,  8'h01,  8'h7F, 1'b0, 1'b1, 0, 0, 1'b0);
    op8(8'h7F,  8'hFF,  8'h80, 1'b1, 1'b1, 0, 0, 1'b0);
    // 100 - 7 = 93 with a stray start mid-RUN, long ack hold, then ack+start.
    op8(8'd100, 8'd7,   8'h5D, 1'b0, 1'b0, 3, 20, 1'b1);

    // Asynchronous reset in RUN cycle 4.
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", busy8, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", {busy8, done8, bor8, ovf8, diff8}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_mid_rst", {busy8, done8}, 0);
    op8(8'd3, 8'd1, 8'h02, 1'b0, 1'b0, 0, 0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4(4'(a), 4'(b));
      end
    end

    repeat (3) @(negedge clk);
    check("sb8_drained", q8.size(), 0);
    check("sb4_drained", q4.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
             pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
